// File: rtl/pico_bus_fabric_if.sv
// rtl/pico_bus_fabric_if.sv - CPU-side and slave-side signals of the picorv32 bus fabric
interface pico_bus_fabric_if #(
    parameter int NUM_SLV = 4
);
    logic                   m_valid;
    logic [31:0]            m_addr;
    logic [31:0]            m_wdata;
    logic [3:0]             m_wstrb;
    logic                   m_ready;
    logic [31:0]            m_rdata;
    logic [NUM_SLV-1:0]     s_sel;
    logic                   s_req;
    logic [31:0]            s_addr;
    logic [31:0]            s_wdata;
    logic [3:0]             s_wstrb;
    logic [NUM_SLV-1:0]     s_ack;
    logic [NUM_SLV*32-1:0]  s_rdata;

    // The fabric takes the slave view: it answers the CPU and drives the slave selects.
    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ack, s_rdata,
        output m_ready, m_rdata, s_sel, s_req, s_addr, s_wdata, s_wstrb
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb, s_ack, s_rdata,
        input  m_ready, m_rdata, s_sel, s_req, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/pico_bus_fabric.sv
// rtl/pico_bus_fabric.sv - picorv32 address decoder with fixed-cycle and req/ack-with-timeout completion
module pico_bus_fabric #(
    parameter int                             NUM_SLV        = 4,
    parameter int                             DECODE_BITS    = 4,
    parameter logic [NUM_SLV*DECODE_BITS-1:0] SLV_TAGS       = {4'h5, 4'h3, 4'h1, 4'h0},
    parameter logic [NUM_SLV-1:0]             SLV_ACK_FIXED  = 4'b0111,
    parameter int                             TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                    ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             rst,
    pico_bus_fabric_if.slave bus,
    input  logic             err_clr,
    output logic             err_flag,
    output logic [31:0]      err_addr,
    output logic [7:0]       err_cnt
);
    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nx;

    logic [IDX_W-1:0] idx, hit_idx;
    logic             hit_any, is_err, ack, expire;
    logic [31:0]      rdata_r, slv_rdata;
    logic [CNT_W-1:0] tmo_cnt, tmo_nxt;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (bus.m_addr[31 -: DECODE_BITS] == SLV_TAGS[i*DECODE_BITS +: DECODE_BITS]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign ack       = bus.s_ack[idx];
    assign slv_rdata = bus.s_rdata[32*idx +: 32];
    assign tmo_nxt   = tmo_cnt + CNT_W'(1);
    assign expire    = (TIMEOUT_CYCLES != 0) && (tmo_nxt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.m_valid) state_nx = (hit_any && !SLV_ACK_FIXED[hit_idx]) ? REQ : DONE;
            REQ:  state_nx = ack ? DONE : WAIT;
            WAIT: if (ack || expire) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.m_ready = (state == DONE);
        bus.s_req   = (state == REQ);
        bus.m_rdata = '0;
        if (state == DONE) begin
            if (is_err)                  bus.m_rdata = ERR_RDATA;
            else if (SLV_ACK_FIXED[idx]) bus.m_rdata = slv_rdata;
            else                         bus.m_rdata = rdata_r;
        end
        bus.s_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            bus.s_sel[i] = bus.m_valid && hit_any && (hit_idx == IDX_W'(i)) && (state != DONE);
        end
    end

    assign bus.s_addr  = bus.m_addr;
    assign bus.s_wdata = bus.m_wdata;
    assign bus.s_wstrb = bus.m_wstrb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            is_err  <= 1'b0;
            rdata_r <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (bus.m_valid) begin
                    idx    <= hit_idx;
                    is_err <= !hit_any;
                end
                REQ: begin
                    tmo_cnt <= '0;
                    if (ack) rdata_r <= slv_rdata;
                end
                WAIT: begin
                    if (ack) begin
                        rdata_r <= slv_rdata;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                        if (expire) is_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (state == DONE && is_err) begin
            err_flag <= 1'b1;
            err_addr <= bus.m_addr;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (err_clr) begin
            err_flag <= 1'b0;
        end
    end
endmodule

// File: doc/pico_bus_fabric.md
Name: pico_bus_fabric

Overview:
Parametrised successor to the hard-coded SoC address-decode/ready FSM. It accepts picorv32 native-bus transactions, decodes them to one of NUM_SLV slave regions, and completes them in one of two ways: a fixed one-cycle path for synchronous memories, or a req/ack handshake with timeout for variable-latency slaves such as the HyperRAM controller. It sits between u_cpu and all slaves and replaces the per-region case statements. Unmapped and timed-out accesses complete with an error response instead of hanging the CPU.

Parameters:
NUM_SLV, 4, number of slave ports (1..16)
DECODE_BITS, 4, width of the address tag, taken from m_addr[31 -: DECODE_BITS]
SLV_TAGS, {4'h5,4'h3,4'h1,4'h0}, packed tags; slice i, i.e. [i*DECODE_BITS +: DECODE_BITS], is the tag for slave i
SLV_ACK_FIXED, 4'b0111, bit i=1: slave i completes in fixed one cycle, and s_ack[i] is ignored
TIMEOUT_CYCLES, 255, wait-cycle limit for handshake slaves; 0 disables the timeout
ERR_RDATA, 32'hDEADBEEF, read data returned on an error

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
m_valid  in  1  CPU request valid
m_addr  in  32  CPU address
m_wdata  in  32  CPU write data
m_wstrb  in  4  byte strobes; 0 means read
m_ready  out  1  one-cycle completion pulse
m_rdata  out  32  read data, valid while m_ready=1
s_sel  out  NUM_SLV  per-slave select
s_req  out  1  one-cycle request pulse to the selected handshake slave
s_addr  out  32  equals m_addr
s_wdata  out  32  equals m_wdata
s_wstrb  out  4  equals m_wstrb
s_ack  in  NUM_SLV  per-slave completion (handshake slaves only)
s_rdata  in  NUM_SLV*32  packed slave read data; slice i belongs to slave i
err_clr  in  1  clears err_flag
err_flag  out  1  sticky error indication
err_addr  out  32  address of the most recent error
err_cnt  out  8  saturating error count

Behaviour:
- State machine states: IDLE, REQ, WAIT, DONE. The state register is 2 bits. Reset puts the state in IDLE.
- Reset values: m_ready=0, s_req=0, err_flag=0, err_addr=0, err_cnt=0. The internal registers idx, is_err, rdata_r and the timeout counter also reset to 0.
- Decode: hit[i] = (m_addr[31 -: DECODE_BITS] == tag i). If several tags match, the lowest index wins. No match means a miss.
- s_sel[i] = m_valid & hit[i] & (state != DONE). It is combinational, so a synchronous ROM or RAM can use it as ce in the acceptance cycle.
- IDLE, m_valid=1:
  - hit on a fixed slave -> DONE;
  - hit on a handshake slave -> REQ;
  - miss -> DONE with is_err=1.
  - idx is latched on acceptance.
- REQ: s_req=1 for exactly this cycle. If s_ack[idx]=1 in this cycle, capture rdata_r=s_rdata[idx] and go to DONE. Otherwise clear the timeout counter and go to WAIT.
- WAIT:
  - s_ack[idx]=1 -> capture rdata_r and go to DONE.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES (nonzero), go to DONE with is_err=1.
  - If ack and expiry occur in the same cycle, the ack wins and there is no error.
  - s_ack bits from non-selected slaves are ignored in every state.
- DONE:
  - m_ready=1 for one cycle, then go to IDLE.
  - m_rdata is ERR_RDATA if is_err; s_rdata[idx] (combinational) for a fixed slave; rdata_r otherwise.
  - Outside DONE, m_rdata=0.
- Latency, counted from the cycle m_valid is first sampled in IDLE:
  - fixed slave: m_ready in cycle +1;
  - handshake slave acking during REQ: m_ready in cycle +2;
  - each additional wait cycle adds 1.
- Error bookkeeping at the DONE cycle with is_err=1: err_flag<=1, err_addr<=m_addr, err_cnt<=err_cnt+1, saturating at 255.
- err_clr clears err_flag only; err_addr and err_cnt are not affected. If err_clr and a new error occur in the same cycle, the set wins.
- Writes to an error target are dropped: no s_sel and no s_req are asserted.
- Asynchronous reset mid-transaction (REQ or WAIT) returns the block to IDLE immediately, and no m_ready is issued. Slaves must tolerate an abandoned request.

Test Plan:
- Read of 0x0000_0010 (slave 0 fixed), with s_rdata slice 0 = 0x1234_5678 -> s_sel=4'b0001 in the acceptance cycle; m_ready one cycle later; m_rdata=0x1234_5678.
- Write of 0x5000_0004 (slave 3 handshake), wdata 0xCAFEF00D, wstrb 4'hF, s_ack[3] raised 10 cycles after s_req -> exactly one s_req pulse; s_wdata=0xCAFEF00D held throughout; m_ready 1 cycle after the ack; no error.
- Read of unmapped 0x7000_0000 -> m_ready at +1; m_rdata=0xDEADBEEF; s_sel=0 and s_req=0 throughout; err_flag=1; err_addr=0x7000_0000; err_cnt=1.
- Handshake read with TIMEOUT_CYCLES=8 and no ack -> error completion after 8 WAIT cycles. A second run with the ack in the expiry cycle -> normal completion carrying the slave data.
- s_ack[2] pulsed while slave 3 is selected -> ignored; the transaction still waits for s_ack[3].
- Assert rst during WAIT -> state IDLE and all error registers 0 immediately. 256 consecutive errors -> err_cnt stays at 255. err_clr pulse -> err_flag=0 and err_cnt unchanged.
